// File: rtl/ll_auto_sync_multi.sv
// rtl/ll_auto_sync_multi.sv - multi-channel TX/RX auto-sync sequencer with RX alignment timeout
// TX bring-up (X wait, Y sync window), RX qualification across all channels (Z wait), sticky timeout.
module ll_auto_sync_multi #(
  parameter int NUM_CH            = 4,
  parameter int MARKER_WIDTH      = 2,
  parameter int PERSISTENT_MARKER = 1,
  parameter int PERSISTENT_STROBE = 1,
  parameter int DLY_W             = 16,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                           clk_wr,
  input  logic                           rst_wr_n,
  input  logic                           tx_online,
  input  logic [NUM_CH-1:0]              rx_online,
  input  logic                           rx_online_holdoff,
  input  logic [DLY_W-1:0]               delay_x_value,
  input  logic [DLY_W-1:0]               delay_y_value,
  input  logic [DLY_W-1:0]               delay_z_value,
  input  logic [MARKER_WIDTH-1:0]        tx_mrk_userbit,
  input  logic                           tx_stb_userbit,
  output logic                           tx_online_delay,
  output logic                           rx_online_delay,
  output logic [NUM_CH*MARKER_WIDTH-1:0] tx_auto_mrk_userbit,
  output logic [NUM_CH-1:0]              tx_auto_stb_userbit,
  output logic                           rx_align_timeout,
  output logic [7:0]                     sync_status
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    TX_OFF    = 2'd0,
    TX_WAIT_X = 2'd1,
    TX_SYNC   = 2'd2,
    TX_ON     = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_OFF    = 2'd0,
    RX_WAIT_Z = 2'd1,
    RX_ON     = 2'd2
  } rx_state_t;

  tx_state_t         r_tx_state, w_tx_state_nxt;
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [DLY_W-1:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [DLY_W-1:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic              r_to_flag, w_to_flag_nxt;
  logic              w_tx_on;
  logic              w_rx_ok;
  logic              w_mrk_en;
  logic              w_stb_en;

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      r_tx_state <= TX_OFF;
      r_rx_state <= RX_OFF;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_to_flag  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_rx_state <= w_rx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_to_flag  <= w_to_flag_nxt;
    end
  end

  // Dropping the TX request overrides every other TX transition.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    if (!tx_online) begin
      w_tx_state_nxt = TX_OFF;
      w_tx_cnt_nxt   = '0;
    end else begin
      case (r_tx_state)
        TX_OFF: begin
          w_tx_state_nxt = TX_WAIT_X;
          w_tx_cnt_nxt   = delay_x_value;
        end
        TX_WAIT_X: begin
          if (r_tx_cnt == '0) begin
            w_tx_state_nxt = TX_SYNC;
            w_tx_cnt_nxt   = delay_y_value;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt - DLY_W'(1);
          end
        end
        TX_SYNC: begin
          if (r_tx_cnt == '0) begin
            w_tx_state_nxt = TX_ON;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt - DLY_W'(1);
          end
        end
        default: w_tx_state_nxt = TX_ON;
      endcase
    end
  end

  assign w_tx_on = (r_tx_state == TX_ON);
  assign w_rx_ok = (&rx_online) & ~rx_online_holdoff & w_tx_on;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    case (r_rx_state)
      RX_OFF: begin
        if (w_rx_ok) begin
          w_rx_state_nxt = RX_WAIT_Z;
          w_rx_cnt_nxt   = delay_z_value;
        end
      end
      RX_WAIT_Z: begin
        if (!w_rx_ok) begin
          w_rx_state_nxt = RX_OFF;
        end else if (r_rx_cnt == '0) begin
          w_rx_state_nxt = RX_ON;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt - DLY_W'(1);
        end
      end
      RX_ON: begin
        if (!w_rx_ok) w_rx_state_nxt = RX_OFF;
      end
      default: w_rx_state_nxt = RX_OFF;
    endcase
  end

  // The flag is raised only on the increment that reaches the limit; a TX drop clears it first.
  always_comb begin
    w_to_cnt_nxt  = r_to_cnt;
    w_to_flag_nxt = r_to_flag;
    if (!w_tx_on || (r_rx_state == RX_ON)) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt != TO_MAX) begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      if ((TIMEOUT_CYCLES != 0) && (w_to_cnt_nxt == TO_MAX)) w_to_flag_nxt = 1'b1;
    end
    if (!tx_online) w_to_flag_nxt = 1'b0;
  end

  assign w_mrk_en = (r_tx_state == TX_SYNC) || (w_tx_on && (PERSISTENT_MARKER != 0));
  assign w_stb_en = (r_tx_state == TX_SYNC) || (w_tx_on && (PERSISTENT_STROBE != 0));

  assign tx_online_delay     = w_tx_on;
  assign rx_online_delay     = (r_rx_state == RX_ON);
  assign tx_auto_mrk_userbit = w_mrk_en ? {NUM_CH{tx_mrk_userbit}} : '0;
  assign tx_auto_stb_userbit = w_stb_en ? {NUM_CH{tx_stb_userbit}} : '0;
  assign rx_align_timeout    = r_to_flag;
  assign sync_status         = {3'b000, r_to_flag, r_rx_state, r_tx_state};

endmodule
